pwm_regs_mc: RTL and testbench
==============================

// Module: pwm_regs_mc
// PURPOSE
//  Multi-channel successor to the single-channel PWM register file. Sits between the
//  bus decoder and NUM_CH counter/PWM channel pairs. Adds double-buffered (shadow)
//  PERIOD/COMPARE registers, a tear-free COUNTER_VAL read, a sticky wrap status with
//  write-1-to-clear, and a level interrupt.
// PARAMETERS
//  NUM_CH  4   number of channels, 1..4; addr[5:4] selects the channel
//  CNT_W   16  counter/period/compare width, 9..16
// PORTS
//  clk            in   1             peripheral clock
//  rst_n          in   1             asynchronous active-low reset
//  read           in   1             read strobe from decoder
//  write          in   1             write strobe from decoder
//  addr           in   6             {ch[1:0], off[3:0]}
//  data_write     in   8             write data
//  data_read      out  8             read data, combinational
//  counter_val    in   NUM_CH*CNT_W  live counter values, channel c at [c*CNT_W +: CNT_W]
//  wrap           in   NUM_CH        1-cycle pulse per channel when its counter wraps
//  period         out  NUM_CH*CNT_W  active (shadow-loaded) period per channel
//  compare1       out  NUM_CH*CNT_W  active compare1 per channel
//  compare2       out  NUM_CH*CNT_W  active compare2 per channel
//  en             out  NUM_CH        counter enable per channel
//  upnotdown      out  NUM_CH        count direction per channel
//  pwm_en         out  NUM_CH        PWM output enable per channel
//  functions      out  NUM_CH*2      PWM function select per channel
//  prescale       out  NUM_CH*8      prescaler per channel
//  count_reset    out  NUM_CH        counter reset pulse per channel
//  irq            out  1             |(status & irq_en) over all channels
// BEHAVIOUR
//  Offsets: 0/1 PERIOD L/H; 2 CTRL {b5 UPD_HOLD, b4:3 FUNC, b2 PWM_EN, b1 UPND, b0 EN};
//   3/4 CMP1 L/H; 5/6 CMP2 L/H; 7 COUNTER_RESET (W, reads 0); 8/9 CNT L/H (R only);
//   A PRESCALE; B STATUS (b0 WRAP, W1C); C IRQ_EN (b0). Other offsets, or ch >= NUM_CH:
//   writes ignored, reads return 0. H bytes hold bits CNT_W-1:8; unused bits read 0.
//  Reset: every register, staging/active copy, snapshot, status and pulse counter is 0;
//   all outputs are 0.
//  Writes take effect on the clk edge where write=1. data_read = 0 when read=0. When
//   read and write are both 1, the read returns the pre-write value.
//  Shadowing: writes to PERIOD/CMP1/CMP2 update staging only. Staging is copied to the
//   active outputs on the edge after wrap[c]=1, or on every edge while en[c]=0, or on
//   the first count_reset cycle. UPD_HOLD=1 blocks all copies, so software can update
//   both bytes without tearing. A write to staging in the same cycle as a copy: the
//   copy takes the old staging value and the new byte appears in staging.
//  Reading staging: PERIOD/CMP reads return staging, not active.
//  Tear-free count: a read of off 8 returns counter_val[7:0] live. On the same edge it
//   latches counter_val[CNT_W-1:8] into a per-channel snapshot. Off 9 returns the snapshot.
//  COUNTER_RESET: a write of any data sets a 2-bit sequencer to 1. The sequencer
//   advances 1 -> 2 -> 3 -> 0. count_reset[c] = 1 in states 1 and 2, i.e. a 2-cycle pulse
//   starting the cycle after the write. A re-write mid-sequence restarts it at 1.
//  STATUS.WRAP is set by wrap[c]. Writing 1 clears it; writing 0 has no effect. If set
//   and clear coincide, set wins. irq is combinational from the registers, with no
//   additional latency.
//  Asynchronous reset mid-sequence or mid-update aborts it immediately. No partial
//   state survives.
// TESTING
//  1 Reset: assert rst_n=0 mid-traffic -> all outputs 0; every readable offset reads 0x00.
//  2 Shadow: en=1, write PERIOD=0x1234 -> period stays 0. Pulse wrap[0] -> period=0x1234
//    on the next edge. Repeat with UPD_HOLD=1 -> no copy.
//  3 Tear-free: counter_val ch1 = 0x12FF, read off 8 -> 0xFF. Counter moves to 0x1300,
//    read off 9 -> 0x12.
//  4 Reset pulse: write ch2 off 7 -> count_reset[2] high for exactly cycles +1,+2.
//    Re-write at +1 -> high through +3.
//  5 W1C race: STATUS.WRAP=1, irq_en=1; write 0x01 to off B in the same cycle as wrap ->
//    WRAP stays 1, irq=1. Next write without wrap -> WRAP=0, irq=0.
//  6 Decode: NUM_CH=2, write ch3 off 0 = 0xAA -> no output changes; read ch3 off 0 -> 0x00.

Source files
------------

// File: rtl/pwm_regs_mc.sv
// pwm_regs_mc: multi-channel PWM register file. It provides shadowed period/compare
// registers, a tear-free counter readback, a W1C wrap status and a level interrupt.
//
// count_reset sequencer, one per channel
//   state    | meaning
//   SEQ_IDLE | no reset in progress
//   SEQ_P1   | count_reset high, first cycle; shadows load at its end
//   SEQ_P2   | count_reset high, second cycle
//   SEQ_TAIL | trailing low cycle before returning to idle
module pwm_regs_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    read,
  input  logic                    write,
  input  logic [5:0]              addr,
  input  logic [7:0]              data_write,
  output logic [7:0]              data_read,
  input  logic [NUM_CH*CNT_W-1:0] counter_val,
  input  logic [NUM_CH-1:0]       wrap,
  output logic [NUM_CH*CNT_W-1:0] period,
  output logic [NUM_CH*CNT_W-1:0] compare1,
  output logic [NUM_CH*CNT_W-1:0] compare2,
  output logic [NUM_CH-1:0]       en,
  output logic [NUM_CH-1:0]       upnotdown,
  output logic [NUM_CH-1:0]       pwm_en,
  output logic [NUM_CH*2-1:0]     functions,
  output logic [NUM_CH*8-1:0]     prescale,
  output logic [NUM_CH-1:0]       count_reset,
  output logic                    irq
);

  localparam int HI_W = CNT_W - 8;

  localparam logic [3:0] OFF_PER_L  = 4'h0;
  localparam logic [3:0] OFF_PER_H  = 4'h1;
  localparam logic [3:0] OFF_CTRL   = 4'h2;
  localparam logic [3:0] OFF_CMP1_L = 4'h3;
  localparam logic [3:0] OFF_CMP1_H = 4'h4;
  localparam logic [3:0] OFF_CMP2_L = 4'h5;
  localparam logic [3:0] OFF_CMP2_H = 4'h6;
  localparam logic [3:0] OFF_CRST   = 4'h7;
  localparam logic [3:0] OFF_CNT_L  = 4'h8;
  localparam logic [3:0] OFF_CNT_H  = 4'h9;
  localparam logic [3:0] OFF_PRE    = 4'hA;
  localparam logic [3:0] OFF_STATUS = 4'hB;
  localparam logic [3:0] OFF_IRQ_EN = 4'hC;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_P1   = 2'd1,
    SEQ_P2   = 2'd2,
    SEQ_TAIL = 2'd3
  } seq_t;

  logic [1:0]        ch;
  logic [3:0]        off;
  logic [7:0]        rd_val [NUM_CH];
  logic [NUM_CH-1:0] irq_vec;

  assign ch  = addr[5:4];
  assign off = addr[3:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [1:0] CH = 2'(c);

    logic             wr_ch;
    logic             rd_ch;
    logic             load;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per_stg;
    logic [CNT_W-1:0] per_act;
    logic [CNT_W-1:0] cmp1_stg;
    logic [CNT_W-1:0] cmp1_act;
    logic [CNT_W-1:0] cmp2_stg;
    logic [CNT_W-1:0] cmp2_act;
    logic [5:0]       ctrl;
    logic [7:0]       pre;
    logic [HI_W-1:0]  snap;
    logic             wrap_st;
    logic             irq_en_r;
    logic             cnt_rst;
    seq_t             seq;
    logic [7:0]       rd_c;

    assign cnt   = counter_val[c*CNT_W +: CNT_W];
    assign wr_ch = write && (ch == CH);
    assign rd_ch = read && (ch == CH);
    // UPD_HOLD gates every load source so both bytes can be staged atomically
    assign load  = !ctrl[5] && (wrap[c] || !ctrl[0] || (seq == SEQ_P1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        per_stg  <= '0;
        per_act  <= '0;
        cmp1_stg <= '0;
        cmp1_act <= '0;
        cmp2_stg <= '0;
        cmp2_act <= '0;
        ctrl     <= '0;
        pre      <= '0;
        snap     <= '0;
        wrap_st  <= 1'b0;
        irq_en_r <= 1'b0;
      end else begin
        if (load) begin
          per_act  <= per_stg;
          cmp1_act <= cmp1_stg;
          cmp2_act <= cmp2_stg;
        end
        if (wr_ch) begin
          case (off)
            OFF_PER_L:  per_stg[7:0]        <= data_write;
            OFF_PER_H:  per_stg[CNT_W-1:8]  <= data_write[HI_W-1:0];
            OFF_CTRL:   ctrl                <= data_write[5:0];
            OFF_CMP1_L: cmp1_stg[7:0]       <= data_write;
            OFF_CMP1_H: cmp1_stg[CNT_W-1:8] <= data_write[HI_W-1:0];
            OFF_CMP2_L: cmp2_stg[7:0]       <= data_write;
            OFF_CMP2_H: cmp2_stg[CNT_W-1:8] <= data_write[HI_W-1:0];
            OFF_PRE:    pre                 <= data_write;
            OFF_IRQ_EN: irq_en_r            <= data_write[0];
            default:    ;
          endcase
        end
        if (rd_ch && (off == OFF_CNT_L)) begin
          snap <= cnt[CNT_W-1:8];
        end
        // a wrap arriving with the W1C write keeps the flag set
        wrap_st <= wrap[c] |
                   (wrap_st & ~(wr_ch && (off == OFF_STATUS) && data_write[0]));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        seq     <= SEQ_IDLE;
        cnt_rst <= 1'b0;
      end else if (wr_ch && (off == OFF_CRST)) begin
        seq     <= SEQ_P1;
        cnt_rst <= 1'b1;
      end else begin
        case (seq)
          SEQ_P1: begin
            seq     <= SEQ_P2;
            cnt_rst <= 1'b1;
          end
          SEQ_P2: begin
            seq     <= SEQ_TAIL;
            cnt_rst <= 1'b0;
          end
          SEQ_TAIL: begin
            seq     <= SEQ_IDLE;
            cnt_rst <= 1'b0;
          end
          default: begin
            seq     <= SEQ_IDLE;
            cnt_rst <= 1'b0;
          end
        endcase
      end
    end

    always_comb begin
      rd_c = 8'h00;
      case (off)
        OFF_PER_L:  rd_c = per_stg[7:0];
        OFF_PER_H:  rd_c = 8'(per_stg[CNT_W-1:8]);
        OFF_CTRL:   rd_c = {2'b00, ctrl};
        OFF_CMP1_L: rd_c = cmp1_stg[7:0];
        OFF_CMP1_H: rd_c = 8'(cmp1_stg[CNT_W-1:8]);
        OFF_CMP2_L: rd_c = cmp2_stg[7:0];
        OFF_CMP2_H: rd_c = 8'(cmp2_stg[CNT_W-1:8]);
        OFF_CNT_L:  rd_c = cnt[7:0];
        OFF_CNT_H:  rd_c = 8'(snap);
        OFF_PRE:    rd_c = pre;
        OFF_STATUS: rd_c = {7'b0, wrap_st};
        OFF_IRQ_EN: rd_c = {7'b0, irq_en_r};
        default:    rd_c = 8'h00;
      endcase
    end

    assign rd_val[c]                    = rd_c;
    assign irq_vec[c]                   = wrap_st & irq_en_r;
    assign period[c*CNT_W +: CNT_W]     = per_act;
    assign compare1[c*CNT_W +: CNT_W]   = cmp1_act;
    assign compare2[c*CNT_W +: CNT_W]   = cmp2_act;
    assign en[c]                        = ctrl[0];
    assign upnotdown[c]                 = ctrl[1];
    assign pwm_en[c]                    = ctrl[2];
    assign functions[c*2 +: 2]          = ctrl[4:3];
    assign prescale[c*8 +: 8]           = pre;
    assign count_reset[c]               = cnt_rst;
  end

  // channels at or above NUM_CH never match, so they read as zero
  always_comb begin
    data_read = 8'h00;
    if (read) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch == 2'(i)) data_read = rd_val[i];
      end
    end
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Bench for pwm_regs_mc: directed scenarios plus random bus/wrap traffic checked
// against a register-level reference model.
module tb_pwm_regs_mc;

  localparam int NC  = 4;
  localparam int CW  = 16;
  localparam int NC2 = 2;
  localparam int CW2 = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic           read, write;
  logic [5:0]     addr;
  logic [7:0]     data_write, data_read;
  logic [NC*CW-1:0] counter_val, period, compare1, compare2;
  logic [NC-1:0]  wrap, en, upnotdown, pwm_en, count_reset;
  logic [NC*2-1:0] functions;
  logic [NC*8-1:0] prescale;
  logic           irq;

  logic           rd2, wr2;
  logic [5:0]     addr2;
  logic [7:0]     dw2, dr2;
  logic [NC2*CW2-1:0] cv2, per2, c1_2, c2_2;
  logic [NC2-1:0] wrap2, en2, ud2, pe2, cr2;
  logic [NC2*2-1:0] fn2;
  logic [NC2*8-1:0] pre2;
  logic           irq2;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [15:0] m_pstg [NC], m_pact [NC], m_c1s [NC], m_c1a [NC], m_c2s [NC], m_c2a [NC];
  logic [5:0]  m_ctrl [NC];
  logic [7:0]  m_pre [NC], m_snap [NC];
  logic        m_st [NC], m_ie [NC];
  int          m_left [NC];

  always #5 clk = ~clk;

  pwm_regs_mc #(.NUM_CH(NC), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .counter_val(counter_val),
    .wrap(wrap), .period(period), .compare1(compare1), .compare2(compare2),
    .en(en), .upnotdown(upnotdown), .pwm_en(pwm_en), .functions(functions),
    .prescale(prescale), .count_reset(count_reset), .irq(irq)
  );

  pwm_regs_mc #(.NUM_CH(NC2), .CNT_W(CW2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .read(rd2), .write(wr2), .addr(addr2),
    .data_write(dw2), .data_read(dr2), .counter_val(cv2),
    .wrap(wrap2), .period(per2), .compare1(c1_2), .compare2(c2_2),
    .en(en2), .upnotdown(ud2), .pwm_en(pe2), .functions(fn2),
    .prescale(pre2), .count_reset(cr2), .irq(irq2)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_pstg[c] = '0; m_pact[c] = '0; m_c1s[c] = '0; m_c1a[c] = '0;
      m_c2s[c] = '0; m_c2a[c] = '0; m_ctrl[c] = '0; m_pre[c] = '0;
      m_snap[c] = '0; m_st[c] = 1'b0; m_ie[c] = 1'b0; m_left[c] = 0;
    end
  endtask

  function automatic logic [7:0] model_read();
    logic [1:0] c;
    c = addr[5:4];
    if (!read) return 8'h00;
    case (addr[3:0])
      4'h0: return m_pstg[c][7:0];
      4'h1: return m_pstg[c][15:8];
      4'h2: return {2'b00, m_ctrl[c]};
      4'h3: return m_c1s[c][7:0];
      4'h4: return m_c1s[c][15:8];
      4'h5: return m_c2s[c][7:0];
      4'h6: return m_c2s[c][15:8];
      4'h8: return counter_val[c*CW +: 8];
      4'h9: return m_snap[c];
      4'hA: return m_pre[c];
      4'hB: return {7'b0, m_st[c]};
      4'hC: return {7'b0, m_ie[c]};
      default: return 8'h00;
    endcase
  endfunction

  // one clock edge of the register file, applied to the model with this cycle's inputs
  task automatic model_update();
    logic [1:0] c;
    logic [3:0] o;
    logic       ld [NC];
    logic       clr;
    c = addr[5:4];
    o = addr[3:0];
    for (int k = 0; k < NC; k++)
      ld[k] = !m_ctrl[k][5] && (wrap[k] || !m_ctrl[k][0] || m_left[k] == 2);
    for (int k = 0; k < NC; k++) begin
      if (ld[k]) begin
        m_pact[k] = m_pstg[k]; m_c1a[k] = m_c1s[k]; m_c2a[k] = m_c2s[k];
      end
      if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
      clr = write && (c == 2'(k)) && (o == 4'hB) && data_write[0];
      m_st[k] = (m_st[k] && !clr) || wrap[k];
    end
    if (read && o == 4'h8) m_snap[c] = counter_val[c*CW + 8 +: 8];
    if (write) begin
      case (o)
        4'h0: m_pstg[c][7:0]  = data_write;
        4'h1: m_pstg[c][15:8] = data_write;
        4'h2: m_ctrl[c]       = data_write[5:0];
        4'h3: m_c1s[c][7:0]   = data_write;
        4'h4: m_c1s[c][15:8]  = data_write;
        4'h5: m_c2s[c][7:0]   = data_write;
        4'h6: m_c2s[c][15:8]  = data_write;
        4'h7: m_left[c]       = 2;
        4'hA: m_pre[c]        = data_write;
        4'hC: m_ie[c]         = data_write[0];
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [NC*CW-1:0] e_per, e_c1, e_c2;
    logic [NC-1:0]    e_en, e_ud, e_pe, e_cr;
    logic [NC*2-1:0]  e_fn;
    logic [NC*8-1:0]  e_pre;
    logic             e_irq;
    e_irq = 1'b0;
    for (int k = 0; k < NC; k++) begin
      e_per[k*CW +: CW] = m_pact[k];
      e_c1[k*CW +: CW]  = m_c1a[k];
      e_c2[k*CW +: CW]  = m_c2a[k];
      e_en[k] = m_ctrl[k][0];
      e_ud[k] = m_ctrl[k][1];
      e_pe[k] = m_ctrl[k][2];
      e_fn[k*2 +: 2] = m_ctrl[k][4:3];
      e_pre[k*8 +: 8] = m_pre[k];
      e_cr[k] = (m_left[k] > 0);
      e_irq = e_irq | (m_st[k] & m_ie[k]);
    end
    chk("period", period, e_per);
    chk("compare1", compare1, e_c1);
    chk("compare2", compare2, e_c2);
    chk("ctrl_bits", {functions, pwm_en, upnotdown, en}, {e_fn, e_pe, e_ud, e_en});
    chk("prescale", prescale, e_pre);
    chk("count_reset", count_reset, e_cr);
    chk("irq", irq, e_irq);
  endtask

  // inputs are set at a falling edge; this checks the read path, takes the rising edge
  // and checks the registered outputs at the following falling edge
  task automatic tick();
    #1;
    chk("data_read_model", data_read, model_read());
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic bus_write(input int c, input int o, input logic [7:0] d);
    write = 1'b1; addr = {2'(c), 4'(o)}; data_write = d;
    tick();
    write = 1'b0;
  endtask

  task automatic bus_read(input string name, input int c, input int o, input logic [7:0] exp);
    read = 1'b1; addr = {2'(c), 4'(o)};
    #1;
    chk(name, data_read, exp);
    tick();
    read = 1'b0;
  endtask

  task automatic bus2_write(input int c, input int o, input logic [7:0] d);
    wr2 = 1'b1; addr2 = {2'(c), 4'(o)}; dw2 = d;
    @(posedge clk); @(negedge clk);
    wr2 = 1'b0;
  endtask

  task automatic bus2_read(input string name, input int c, input int o, input logic [7:0] exp);
    rd2 = 1'b1; addr2 = {2'(c), 4'(o)};
    #1;
    chk(name, dr2, exp);
    @(posedge clk); @(negedge clk);
    rd2 = 1'b0;
  endtask

  initial begin
    read = 0; write = 0; addr = 0; data_write = 0; counter_val = '0; wrap = '0;
    rd2 = 0; wr2 = 0; addr2 = 0; dw2 = 0; cv2 = '0; wrap2 = '0;
    model_reset();
    #12;
    chk("reset_period", period, 64'h0);
    chk("reset_ctrl", {functions, pwm_en, upnotdown, en, count_reset, irq}, 64'h0);
    chk("reset_prescale", prescale, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // shadowed period: staging only until wrap, and UPD_HOLD blocks the load
    bus_write(0, 2, 8'h01);
    chk("en_set", en, 4'b0001);
    bus_write(0, 0, 8'h34);
    bus_write(0, 1, 8'h12);
    chk("shadow_no_load", period[15:0], 16'h0000);
    wrap = 4'b0001; tick(); wrap = 4'b0000;
    chk("shadow_wrap_load", period[15:0], 16'h1234);
    bus_write(0, 2, 8'h21);
    bus_write(0, 0, 8'h78);
    bus_write(0, 1, 8'h56);
    wrap = 4'b0001; tick(); wrap = 4'b0000;
    chk("hold_blocks", period[15:0], 16'h1234);
    bus_read("staging_rd_l", 0, 0, 8'h78);
    bus_read("staging_rd_h", 0, 1, 8'h56);
    bus_write(0, 2, 8'h01);
    chk("hold_release_no_load", period[15:0], 16'h1234);
    wrap = 4'b0001; tick(); wrap = 4'b0000;
    chk("release_wrap_load", period[15:0], 16'h5678);

    // count_reset loads the shadows at the end of its first cycle
    bus_write(0, 0, 8'hBC);
    bus_write(0, 1, 8'h9A);
    bus_write(0, 7, 8'h00);
    chk("crst_first_cycle", {count_reset[0], period[15:0]}, {1'b1, 16'h5678});
    tick();
    chk("crst_load", period[15:0], 16'h9ABC);

    // tear-free counter read on channel 1
    counter_val[31:16] = 16'h12FF;
    bus_read("cnt_low", 1, 8, 8'hFF);
    counter_val[31:16] = 16'h1300;
    bus_read("cnt_snap", 1, 9, 8'h12);

    // count_reset pulse width and restart on channel 2
    bus_write(2, 7, 8'hFF);
    chk("crst_p1", count_reset[2], 1'b1);
    tick();
    chk("crst_p2", count_reset[2], 1'b1);
    tick();
    chk("crst_p3_low", count_reset[2], 1'b0);
    tick();
    chk("crst_p4_low", count_reset[2], 1'b0);
    bus_write(2, 7, 8'h00);
    chk("crst_r1", count_reset[2], 1'b1);
    bus_write(2, 7, 8'h00);
    chk("crst_r2", count_reset[2], 1'b1);
    tick();
    chk("crst_r3", count_reset[2], 1'b1);
    tick();
    chk("crst_r4_low", count_reset[2], 1'b0);
    bus_read("crst_reads_0", 2, 7, 8'h00);

    // W1C race on channel 3: set wins, later clear works, writing 0 is a no-op
    bus_write(3, 12, 8'h01);
    wrap = 4'b1000; tick(); wrap = 4'b0000;
    chk("irq_set", irq, 1'b1);
    wrap = 4'b1000;
    bus_write(3, 11, 8'h01);
    wrap = 4'b0000;
    chk("w1c_race_irq", irq, 1'b1);
    bus_read("w1c_race_st", 3, 11, 8'h01);
    bus_write(3, 11, 8'h00);
    chk("w0_noop_irq", irq, 1'b1);
    bus_write(3, 11, 8'h01);
    chk("w1c_clear_irq", irq, 1'b0);
    bus_read("w1c_clear_st", 3, 11, 8'h00);

    // decode with NUM_CH=2, CNT_W=12
    bus2_write(3, 0, 8'hAA);
    bus2_write(2, 2, 8'h3F);
    chk("dec_outputs", {per2, c1_2, c2_2, en2, ud2, pe2, fn2, cr2, irq2}, 64'h0);
    chk("dec_prescale", pre2, 16'h0);
    bus2_read("dec_rd_ch3", 3, 0, 8'h00);
    bus2_read("dec_rd_ch2", 2, 2, 8'h00);
    bus2_write(1, 0, 8'h5A);
    bus2_write(1, 1, 8'hFF);
    chk("dec_old_staging", per2, {12'h05A, 12'h000});
    @(posedge clk); @(negedge clk);
    chk("dec_cw12_load", per2, {12'hF5A, 12'h000});
    bus2_read("dec_hi_mask", 1, 1, 8'h0F);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      read = 1'($urandom_range(0, 1));
      write = ($urandom_range(0, 2) == 0);
      addr = 6'($urandom);
      data_write = 8'($urandom);
      counter_val = {$urandom, $urandom};
      wrap = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      tick();
    end

    // asynchronous reset in the middle of a count_reset sequence and traffic
    read = 0; write = 0;
    bus_write(1, 7, 8'h00);
    write = 1'b1; addr = 6'h20; data_write = 8'h77; wrap = 4'hF;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_period", {period, compare1}, 64'h0);
    chk("arst_ctrl", {compare2[47:0], functions, pwm_en, upnotdown, en}, 64'h0);
    chk("arst_misc", {prescale, count_reset, irq}, 64'h0);
    model_reset();
    @(negedge clk);
    write = 0; read = 0; wrap = '0; counter_val = '0; addr = 0; data_write = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < NC; c++)
      for (int o = 0; o < 16; o++)
        bus_read("arst_sweep", c, o, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
